// File: rtl/dmux_stream_router_if.sv
// Stream bundle between a single source and the NCH-way router fan-out.
// The slave modport is the router's view; master is the source/consumer side.
interface dmux_stream_router_if #(
   parameter int WIDTH = 16,
   parameter int SEL_W = 3
);
   localparam int NCH = 1 << SEL_W;

   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_data;
   logic [SEL_W-1:0]       in_sel;
   logic                   in_bcast;
   logic [NCH-1:0]         out_valid;
   logic [NCH-1:0]         out_ready;
   logic [NCH*WIDTH-1:0]   out_data;
   logic [15:0]            xfer_count;

   modport slave (
      input  in_valid, in_data, in_sel, in_bcast, out_ready,
      output in_ready, out_valid, out_data, xfer_count
   );

   modport master (
      output in_valid, in_data, in_sel, in_bcast, out_ready,
      input  in_ready, out_valid, out_data, xfer_count
   );
endinterface

// File: rtl/dmux_stream_router.sv
// Registered valid/ready demultiplexer: one input stream fanned out to 2**SEL_W
// channels, each with a 1-entry holding register, plus optional broadcast.
module dmux_stream_router #(
   parameter int WIDTH    = 16,
   parameter int SEL_W    = 3,
   parameter bit BCAST_EN = 1'b1
) (
   input logic               clk,
   input logic               reset,
   dmux_stream_router_if.slave bus
);
   localparam int NCH = 1 << SEL_W;

   logic [NCH-1:0]       full;
   logic [NCH-1:0]       free;
   logic [NCH-1:0]       target;
   logic [NCH-1:0]       load;
   logic [NCH*WIDTH-1:0] data_q;
   logic [15:0]          count;
   logic                 bc;
   logic                 ready;
   logic                 accept;

   // A channel can take a new word if empty or if its current word drains this cycle.
   always_comb begin
      bc     = bus.in_bcast & BCAST_EN;
      free   = ~full | bus.out_ready;
      ready  = !reset & (bc ? (&free) : free[bus.in_sel]);
      accept = bus.in_valid & ready;
      target = bc ? {NCH{1'b1}} : ({{(NCH-1){1'b0}}, 1'b1} << bus.in_sel);
      load   = accept ? target : {NCH{1'b0}};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full   <= '0;
         data_q <= '0;
         count  <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (load[i]) begin
               full[i]                  <= 1'b1;
               data_q[i*WIDTH +: WIDTH] <= bus.in_data;
            end else if (bus.out_ready[i]) begin
               full[i] <= 1'b0;
            end
         end
         count <= count + {15'd0, accept};
      end
   end

   assign bus.in_ready   = ready;
   assign bus.out_valid  = full;
   assign bus.out_data   = data_q;
   assign bus.xfer_count = count;
endmodule

// File: tb/tb_dmux_stream_router.sv
// Directed vector bench for dmux_stream_router: table-driven unicast/stall/broadcast
// sequences plus hand-written unicast-only build, mid-operation reset and counter wrap.
module tb_dmux_stream_router;
   logic clk = 1'b0;
   logic reset;

   int num_checks = 0;
   int num_fails  = 0;

   dmux_stream_router_if #(.WIDTH(16), .SEL_W(3)) if1 ();
   dmux_stream_router_if #(.WIDTH(16), .SEL_W(3)) if2 ();

   dmux_stream_router #(.WIDTH(16), .SEL_W(3), .BCAST_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (if1.slave)
   );

   dmux_stream_router #(.WIDTH(16), .SEL_W(3), .BCAST_EN(1'b0)) dut_nobc (
      .clk   (clk),
      .reset (reset),
      .bus   (if2.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        bc;
      logic [2:0]  sel;
      logic [15:0] d;
      logic [7:0]  ordy;
      logic        exp_rdy;
      logic [7:0]  exp_ov;
      int          chk;
      logic [15:0] exp_cd;
      logic [15:0] exp_cnt;
   } vector_t;

   vector_t vecs[15];

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Inputs change on the falling edge so the DUT sees them stable at the rising edge.
   task automatic applyStimulus(input logic v, input logic bc, input logic [2:0] sel,
                                input logic [15:0] d, input logic [7:0] ordy);
      @(negedge clk);
      if1.in_valid  = v;
      if1.in_bcast  = bc;
      if1.in_sel    = sel;
      if1.in_data   = d;
      if1.out_ready = ordy;
   endtask

   initial begin
      logic [15:0] ch;

      reset = 1'b1;
      if1.in_valid = 1'b0; if1.in_bcast = 1'b0; if1.in_sel = '0; if1.in_data = '0; if1.out_ready = '0;
      if2.in_valid = 1'b0; if2.in_bcast = 1'b0; if2.in_sel = '0; if2.in_data = '0; if2.out_ready = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("reset out_valid", 128'(if1.out_valid), 128'h0);
      checkOutput("reset out_data", if1.out_data, 128'h0);
      checkOutput("reset xfer_count", 128'(if1.xfer_count), 128'h0);
      checkOutput("reset in_ready", 128'(if1.in_ready), 128'h1);

      //         v  bc sel  data      ordy   rdy  ov     chk data      cnt
      vecs[0]  = '{1, 0, 3'd5, 16'h1234, 8'hFF, 1, 8'h20, 5, 16'h1234, 16'd1};
      vecs[1]  = '{0, 0, 3'd0, 16'h0000, 8'hFB, 1, 8'h00, 5, 16'h1234, 16'd1};
      vecs[2]  = '{1, 0, 3'd2, 16'hAAAA, 8'hFB, 1, 8'h04, 2, 16'hAAAA, 16'd2};
      vecs[3]  = '{1, 0, 3'd2, 16'hBBBB, 8'hFB, 0, 8'h04, 2, 16'hAAAA, 16'd2};
      vecs[4]  = '{1, 0, 3'd3, 16'hCCCC, 8'hFB, 1, 8'h0C, 3, 16'hCCCC, 16'd3};
      vecs[5]  = '{1, 0, 3'd2, 16'hBBBB, 8'hFF, 1, 8'h04, 2, 16'hBBBB, 16'd4};
      vecs[6]  = '{0, 0, 3'd0, 16'h0000, 8'hFF, 1, 8'h00, 2, 16'hBBBB, 16'd4};
      vecs[7]  = '{1, 0, 3'd7, 16'h7777, 8'h7F, 1, 8'h80, 7, 16'h7777, 16'd5};
      vecs[8]  = '{1, 1, 3'd0, 16'h00FF, 8'h7F, 0, 8'h80, 0, 16'h0000, 16'd5};
      vecs[9]  = '{1, 1, 3'd0, 16'h00FF, 8'hFF, 1, 8'hFF, 0, 16'h00FF, 16'd6};
      vecs[10] = '{0, 0, 3'd0, 16'h0000, 8'hFF, 1, 8'h00, 7, 16'h00FF, 16'd6};
      vecs[11] = '{1, 0, 3'd1, 16'h0001, 8'hFF, 1, 8'h02, 1, 16'h0001, 16'd7};
      vecs[12] = '{1, 0, 3'd1, 16'h0002, 8'hFF, 1, 8'h02, 1, 16'h0002, 16'd8};
      vecs[13] = '{1, 0, 3'd1, 16'h0003, 8'hFF, 1, 8'h02, 1, 16'h0003, 16'd9};
      vecs[14] = '{1, 0, 3'd1, 16'h0004, 8'hFD, 0, 8'h02, 1, 16'h0003, 16'd9};

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].v, vecs[i].bc, vecs[i].sel, vecs[i].d, vecs[i].ordy);
         #1;
         checkOutput($sformatf("v%0d in_ready", i), 128'(if1.in_ready), 128'(vecs[i].exp_rdy));
         @(posedge clk);
         #1;
         ch = if1.out_data[vecs[i].chk*16 +: 16];
         checkOutput($sformatf("v%0d out_valid", i), 128'(if1.out_valid), 128'(vecs[i].exp_ov));
         checkOutput($sformatf("v%0d ch%0d data", i, vecs[i].chk), 128'(ch), 128'(vecs[i].exp_cd));
         checkOutput($sformatf("v%0d xfer_count", i), 128'(if1.xfer_count), 128'(vecs[i].exp_cnt));
      end

      // Unicast-only build: in_bcast must be ignored.
      @(negedge clk);
      if2.in_valid = 1'b1; if2.in_bcast = 1'b1; if2.in_sel = 3'd4; if2.in_data = 16'h5555; if2.out_ready = 8'hFF;
      #1;
      checkOutput("nobc in_ready", 128'(if2.in_ready), 128'h1);
      @(posedge clk);
      #1;
      checkOutput("nobc out_valid", 128'(if2.out_valid), 128'h10);
      checkOutput("nobc ch4 data", 128'(if2.out_data[4*16 +: 16]), 128'h5555);
      checkOutput("nobc ch0 data", 128'(if2.out_data[0 +: 16]), 128'h0);
      checkOutput("nobc xfer_count", 128'(if2.xfer_count), 128'h1);
      @(negedge clk);
      if2.in_sel = 3'd0; if2.in_data = 16'h6666; if2.out_ready = 8'hEF;
      #1;
      checkOutput("nobc stalled ch4 ignored", 128'(if2.in_ready), 128'h1);
      @(negedge clk);
      if2.in_valid = 1'b0;

      // Bring count to 0x0010 with channels 0, 3, 5, 6 holding words.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, 3'd6, 16'h0600 + 16'(i), 8'hFF);
         @(posedge clk);
      end
      applyStimulus(1, 0, 3'd0, 16'h0A00, 8'h00);
      @(posedge clk);
      applyStimulus(1, 0, 3'd3, 16'h0A03, 8'h00);
      @(posedge clk);
      applyStimulus(1, 0, 3'd5, 16'h0A05, 8'h00);
      @(posedge clk);
      #1;
      checkOutput("pre-reset xfer_count", 128'(if1.xfer_count), 128'h10);
      checkOutput("pre-reset out_valid", 128'(if1.out_valid), 128'h69);

      applyStimulus(1, 0, 3'd2, 16'hDEAD, 8'h00);
      reset = 1'b1;
      #1;
      checkOutput("in_ready during reset", 128'(if1.in_ready), 128'h0);
      @(posedge clk);
      #1;
      checkOutput("mid-reset out_valid", 128'(if1.out_valid), 128'h0);
      checkOutput("mid-reset out_data", if1.out_data, 128'h0);
      checkOutput("mid-reset xfer_count", 128'(if1.xfer_count), 128'h0);
      applyStimulus(0, 0, 3'd0, 16'h0000, 8'h00);
      reset = 1'b0;
      for (int s = 0; s < 8; s++) begin
         if1.in_sel = 3'(s);
         #1;
         checkOutput($sformatf("post-reset in_ready sel%0d", s), 128'(if1.in_ready), 128'h1);
      end

      // Counter wrap: 65535 accepts reach 0xFFFF, one more wraps to zero.
      for (int i = 0; i < 65535; i++) begin
         applyStimulus(1, 0, 3'(i), 16'(i), 8'hFF);
         @(posedge clk);
      end
      #1;
      checkOutput("count at 0xFFFF", 128'(if1.xfer_count), 128'hFFFF);
      applyStimulus(1, 0, 3'd0, 16'h0000, 8'hFF);
      @(posedge clk);
      #1;
      checkOutput("count wrap", 128'(if1.xfer_count), 128'h0);
      applyStimulus(0, 0, 3'd0, 16'h0000, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end
endmodule
